// File: rtl/sum_writeback_if.sv
// Stream-in / memory-write bundle for sum_writeback.
// The slave side is the writeback block: it consumes the adder's sum stream
// and drives the destination-memory write port. The master side is whatever
// sits around it (adder + memory, or a testbench).
interface sum_writeback_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] DIn;
   logic              DInValid;
   logic              DInReady;
   logic              WStall;
   logic              WEn;
   logic [ADDR_W-1:0] WAddr;
   logic [DATA_W-1:0] WData;

   modport master (
      output DIn, DInValid, WStall,
      input  DInReady, WEn, WAddr, WData
   );

   modport slave (
      input  DIn, DInValid, WStall,
      output DInReady, WEn, WAddr, WData
   );
endinterface

// File: rtl/sum_writeback.sv
// Sum writeback: buffers adder results in a small FIFO and writes them to
// consecutive destination-memory addresses starting at a programmed base,
// pulsing Done once the programmed word count has been committed.
module sum_writeback #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic              Abort,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [ADDR_W:0]   Count,
   sum_writeback_if.slave    bus,
   output logic              Busy,
   output logic              Done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Control state
   state_t             r_state;
   logic [ADDR_W-1:0]  r_base;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_accepted;
   logic [CNT_W-1:0]   r_written;

   // Input buffer
   logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [OCC_W-1:0]   r_occ;

   // Registered outputs
   logic               r_wen;
   logic [ADDR_W-1:0]  r_waddr;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_busy;
   logic               r_done;

   // Per-edge decisions
   logic               w_run;
   logic               w_abort;
   logic               w_full;
   logic               w_empty;
   logic               w_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_last_pop;

   assign w_run   = (r_state == ST_RUN);
   assign w_abort = w_run & Abort;
   assign w_full  = (r_occ == OCC_FULL);
   assign w_empty = (r_occ == '0);

   // Ready depends only on registered state so the upstream adder never sees
   // a combinational path from its own valid back to ready.
   assign w_ready = w_run & ~w_full & (r_accepted < r_count);

   // Abort discards everything on its edge, including a handshake or a pop.
   assign w_push     = w_ready & bus.DInValid & ~w_abort;
   assign w_pop      = w_run & ~w_empty & ~bus.WStall & ~w_abort;
   assign w_last_pop = w_pop & ((r_written + CNT_ONE) == r_count);

   assign bus.DInReady = w_ready;
   assign bus.WEn      = r_wen;
   assign bus.WAddr    = r_waddr;
   assign bus.WData    = r_wdata;
   assign Busy         = r_busy;
   assign Done         = r_done;

   // FIFO storage: written on push, read at the head on pop.
   // NOTE: the data array has no reset; emptiness is defined solely by the
   // pointers and occupancy, so stale words are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= bus.DIn;
      end
   end

   // FIFO pointers and occupancy; Abort flushes by clearing them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Transfer FSM with registered write port, Busy and Done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_base     <= '0;
         r_count    <= '0;
         r_accepted <= '0;
         r_written  <= '0;
         r_wen      <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every decision below
         // sees the pre-edge values of the state it reads; the pulse defaults
         // are then overridden by the branches that need them high.
         r_wen  <= 1'b0;
         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  if (Count != '0) begin
                     r_base     <= BaseAddr;
                     r_count    <= Count;
                     r_accepted <= '0;
                     r_written  <= '0;
                     r_busy     <= 1'b1;
                     r_state    <= ST_RUN;
                  end else begin
                     // Empty transfer completes immediately without leaving IDLE.
                     r_done <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (Abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  if (w_push) begin
                     r_accepted <= r_accepted + CNT_ONE;
                  end
                  if (w_pop) begin
                     r_wen     <= 1'b1;
                     r_wdata   <= r_fifo[r_rd_ptr];
                     // Address arithmetic wraps modulo the memory size.
                     r_waddr   <= r_base + r_written[ADDR_W-1:0];
                     r_written <= r_written + CNT_ONE;
                     if (w_last_pop) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end
                  end
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
